// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// EX drives the request side; the MDU returns status, HI/LO and the mfhi/mflo read value.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             occupied;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, op, a, b,
    input  busy, occupied, hi, lo, rd_data
  );

  modport slave (
    input  start, op, a, b,
    output busy, occupied, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit holding HI/LO; the result is computed at accept
// time and committed after a fixed latency so the hazard unit sees a multi-cycle op.
module mdu_iterative #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mdu_iterative_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] OP_MULT  = 5'd0;
  localparam logic [4:0] OP_MULTU = 5'd1;
  localparam logic [4:0] OP_DIV   = 5'd2;
  localparam logic [4:0] OP_DIVU  = 5'd3;
  localparam logic [4:0] OP_MFHI  = 5'd4;
  localparam logic [4:0] OP_MFLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MTLO  = 5'd7;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [4:0]       cnt, cnt_d;
  logic [WIDTH-1:0] hi_r, hi_d;
  logic [WIDTH-1:0] lo_r, lo_d;
  logic [WIDTH-1:0] p_hi, p_hi_d;
  logic [WIDTH-1:0] p_lo, p_lo_d;
  logic             busy_r, busy_d;

  logic signed [2*WIDTH-1:0] a_sext, b_sext, prod_s;
  logic        [2*WIDTH-1:0] a_zext, b_zext, prod_u;
  logic signed [WIDTH-1:0]   sa, sb_safe, quo_s, rem_s;
  logic        [WIDTH-1:0]   b_safe, quo_u, rem_u;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   res_hi, res_lo;

  // Operands are widened explicitly so both products are full 2*WIDTH results.
  assign a_sext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_sext = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign a_zext = {{WIDTH{1'b0}}, bus.a};
  assign b_zext = {{WIDTH{1'b0}}, bus.b};
  assign prod_s = a_sext * b_sext;
  assign prod_u = a_zext * b_zext;

  // A zero divisor is swapped for one so the dividers never produce X; that result is discarded.
  assign div_zero = (bus.b == '0);
  assign div_ovf  = (bus.a == MIN_NEG) && (bus.b == ALL_ONE);
  assign b_safe   = div_zero ? ONE : bus.b;
  assign sa       = $signed(bus.a);
  assign sb_safe  = $signed(b_safe);
  assign quo_s    = sa / sb_safe;
  assign rem_s    = sa % sb_safe;
  assign quo_u    = bus.a / b_safe;
  assign rem_u    = bus.a % b_safe;

  always_comb begin
    res_hi = hi_r;
    res_lo = lo_r;
    case (bus.op)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = '0;
          res_lo = MIN_NEG;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi_r;
    lo_d    = lo_r;
    p_hi_d  = p_hi;
    p_lo_d  = p_lo;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              p_hi_d  = res_hi;
              p_lo_d  = res_lo;
              cnt_d   = MULT_LOAD;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              p_hi_d  = res_hi;
              p_lo_d  = res_lo;
              cnt_d   = DIV_LOAD;
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests arriving here are dropped; the hazard unit holds them via occupied.
        if (cnt == 5'd0) begin
          hi_d    = p_hi;
          lo_d    = p_lo;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      hi_r   <= hi_d;
      lo_r   <= lo_d;
      p_hi   <= p_hi_d;
      p_lo   <= p_lo_d;
      busy_r <= busy_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (bus.op == OP_MFHI) bus.rd_data = hi_r;
    else if (bus.op == OP_MFLO) bus.rd_data = lo_r;
  end

  assign bus.busy     = busy_r;
  assign bus.occupied = bus.start | busy_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: arithmetic results, latency, mthi/mtlo/mfhi/mflo,
// mid-run reset and back-to-back issue, all against hand-computed values.
module tb_mdu_iterative;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_iterative_if #(.WIDTH(32)) bus ();

  mdu_iterative #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    bus.op = 5'd4;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h expected %h", bus.busy, 1'b0); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.occupied !== 1'b0) begin errors++; $display("FAIL reset_occupied got %h expected %h", bus.occupied, 1'b0); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h expected %h", bus.rd_data, 32'h0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult;
    int n;
    issue(5'd0, 32'hFFFF_FFFE, 32'd3);
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mult_hi_midrun got %h expected %h", bus.hi, 32'h0); end
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got %0d expected %0d", n, 5); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h expected %h", bus.lo, 32'hFFFF_FFFA); end
  endtask

  task automatic test_multu;
    int n;
    issue(5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo_midrun got %h expected %h", bus.lo, 32'hFFFF_FFFA); end
    count_busy(n);
    checks++; if (n != 4) begin errors++; $display("FAIL multu_busy_cycles got %0d expected %0d", n, 4); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h expected %h", bus.hi, 32'hFFFF_FFFE); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h expected %h", bus.lo, 32'h0000_0001); end
  endtask

  task automatic test_div;
    logic [4:0]  ops [4] = '{5'd2, 5'd2, 5'd3, 5'd2};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd7, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd2, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'h0};
    logic [31:0] el  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000};
    int n;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      count_busy(n);
      checks++; if (n != 10) begin errors++; $display("FAIL div%0d_busy_cycles got %0d expected %0d", i, n, 10); end
      checks++; if (bus.hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi got %h expected %h", i, bus.hi, eh[i]); end
      checks++; if (bus.lo !== el[i]) begin errors++; $display("FAIL div%0d_lo got %h expected %h", i, bus.lo, el[i]); end
    end
  endtask

  task automatic test_move_and_divzero;
    int n;
    bus.start = 1'b1;
    bus.op    = 5'd6;
    bus.a     = 32'h1234;
    #1;
    checks++; if (bus.occupied !== 1'b1) begin errors++; $display("FAIL occupied_on_start got %h expected %h", bus.occupied, 1'b1); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h expected %h", bus.hi, 32'h1234); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h expected %h", bus.busy, 1'b0); end
    issue(5'd7, 32'h5678, 32'h0);
    bus.op = 5'd4;
    #1;
    checks++; if (bus.rd_data !== 32'h1234) begin errors++; $display("FAIL mfhi_rd got %h expected %h", bus.rd_data, 32'h1234); end
    bus.op = 5'd5;
    #1;
    checks++; if (bus.rd_data !== 32'h5678) begin errors++; $display("FAIL mflo_rd got %h expected %h", bus.rd_data, 32'h5678); end
    issue(5'd9, 32'hAAAA_AAAA, 32'd3);
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL undef_rd got %h expected %h", bus.rd_data, 32'h0); end
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h1234) begin errors++; $display("FAIL undef_noop got busy %h hi %h expected busy 0 hi %h", bus.busy, bus.hi, 32'h1234); end
    issue(5'd3, 32'd99, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_cycles got %0d expected %0d", n, 10); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL divzero_hi got %h expected %h", bus.hi, 32'h1234); end
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL divzero_lo got %h expected %h", bus.lo, 32'h5678); end
  endtask

  task automatic test_reset_midrun;
    issue(5'd2, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    issue(5'd6, 32'hDEAD, 32'd0);
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_in_run_hi got %h expected %h", bus.hi, 32'h1234); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %h expected %h", bus.busy, 1'b1); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %h expected %h", bus.busy, 1'b0); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL midrun_reset_hilo got %h/%h expected 0/0", bus.hi, bus.lo); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (bus.lo !== 32'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_discard got lo %h busy %h expected lo 0 busy 0", bus.lo, bus.busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(5'd0, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    // Held through the last RUN cycle: dropped there, accepted on the next edge.
    bus.start = 1'b1;
    bus.op    = 5'd0;
    bus.a     = 32'hFFFF_FFFB;
    bus.b     = 32'd6;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done_busy got %h expected %h", bus.busy, 1'b0); end
    checks++; if (bus.lo !== 32'd12 || bus.hi !== 32'h0) begin errors++; $display("FAIL b2b_first got %h/%h expected 0/0000000c", bus.hi, bus.lo); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %h expected %h", bus.busy, 1'b1); end
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_busy_cycles got %0d expected %0d", n, 5); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
    checks++; if (bus.lo !== 32'hFFFF_FFE2) begin errors++; $display("FAIL b2b_lo got %h expected %h", bus.lo, 32'hFFFF_FFE2); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 5'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move_and_divzero();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
